// File: rtl/m_rv_pkg.sv
// Shared definitions for the RV32M divide/remainder unit.
//   - operation encodings as presented on w_op
//   - FSM state encodings (also visible on the unit's debug state output)
//   - XLEN constant and small operand helpers used at accept time
package m_rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // DIV and REM interpret operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Magnitude of a value whose sign has already been decided.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                              input logic            neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/m_div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   w_rem       partial remainder from the previous step (low XLEN-1 bits;
//               between steps it is always below 2**(XLEN-1))
//   w_dvd_msb   next dividend bit shifted into the remainder
//   w_dvs       divisor magnitude
//   w_rem_next  remainder after the trial subtraction (restored on borrow)
//   w_q_bit     quotient bit produced by this step
module m_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-2:0] w_rem,
  input  logic            w_dvd_msb,
  input  logic [XLEN-1:0] w_dvs,
  output logic [XLEN-1:0] w_rem_next,
  output logic            w_q_bit
);

  logic [XLEN-1:0] trial;
  logic [XLEN:0]   diff;

  assign trial = {w_rem, w_dvd_msb};
  // Extra top bit is the borrow: set means trial < divisor, so restore.
  assign diff       = {1'b0, trial} - {1'b0, w_dvs};
  assign w_q_bit    = ~diff[XLEN];
  assign w_rem_next = w_q_bit ? diff[XLEN-1:0] : trial;

endmodule

// File: rtl/m_div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Takes rs1/rs2/rd from the register-file read stage and presents a
// write-back request that drives the RF write port directly.
// Ports:
//   w_clk, w_rst          clock, synchronous active-high reset
//   w_in_valid/w_in_ready request handshake (ready only in IDLE)
//   w_op, w_rs1, w_rs2    operation, dividend, divisor
//   w_rd                  destination register index
//   w_busy                high while an operation is in flight (CALC/DONE)
//   w_out_valid/w_out_ack result handshake toward write-back arbitration
//   w_wa, w_wd, w_we      RF write address, data, enable
//   w_dbg_state           current FSM state (div_state_e encoding)
//
// Handshakes: a request is taken on the rising edge where
// w_in_valid & w_in_ready; inputs are ignored at any other time. A result
// is retired on the rising edge where w_out_valid & w_out_ack; w_wa/w_wd
// stay stable until then, and w_out_ack without w_out_valid is ignored.
// w_we is the same-cycle qualification of that retire edge, suppressed
// for rd = x0.
module m_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            w_clk,
  input  logic            w_rst,
  input  logic            w_in_valid,
  output logic            w_in_ready,
  input  logic [1:0]      w_op,
  input  logic [XLEN-1:0] w_rs1,
  input  logic [XLEN-1:0] w_rs2,
  input  logic [4:0]      w_rd,
  output logic            w_busy,
  output logic            w_out_valid,
  input  logic            w_out_ack,
  output logic [4:0]      w_wa,
  output logic [XLEN-1:0] w_wd,
  output logic            w_we,
  output logic [1:0]      w_dbg_state
);

  import m_rv_pkg::*;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] dvd_q;   // dividend magnitude, shifted left each step
  logic [XLEN-1:0] dvs_q;   // divisor magnitude
  // Partial remainder between steps never reaches 2**(XLEN-1), so only
  // XLEN-1 bits are kept; the last step's full remainder goes straight
  // into the result.
  logic [XLEN-2:0] rem_q;
  logic [XLEN-2:0] quo_q;   // quotient bits of all steps except the last
  logic            neg_q;   // negate the selected result at the end
  logic            rem_op_q;
  logic [4:0]      wa_q;
  logic [XLEN-1:0] wd_q;

  // Accept-time decode.
  logic            in_signed;
  logic            s1, s2;
  logic            div_zero, overflow;
  logic [XLEN-1:0] special_res;

  assign in_signed = op_is_signed(w_op);
  assign s1        = in_signed & w_rs1[XLEN-1];
  assign s2        = in_signed & w_rs2[XLEN-1];
  assign div_zero  = (w_rs2 == '0);
  assign overflow  = in_signed & (w_rs1 == INT_MIN) & (&w_rs2);

  // Results the RISC-V ISA defines without dividing.
  always_comb begin
    special_res = '0;
    if (op_is_rem(w_op)) begin
      special_res = div_zero ? w_rs1 : '0;
    end else begin
      special_res = div_zero ? '1 : INT_MIN;
    end
  end

  // Datapath step.
  logic [XLEN-1:0] rem_next;
  logic            q_bit;

  m_div_step #(.XLEN(XLEN)) u_step (
    .w_rem      (rem_q),
    .w_dvd_msb  (dvd_q[XLEN-1]),
    .w_dvs      (dvs_q),
    .w_rem_next (rem_next),
    .w_q_bit    (q_bit)
  );

  // Final result as seen on the last CALC edge, with sign fix-up.
  logic [XLEN-1:0] quo_fin;
  logic [XLEN-1:0] mag_fin;
  logic [XLEN-1:0] res_fin;

  assign quo_fin = {quo_q, q_bit};
  assign mag_fin = rem_op_q ? rem_next : quo_fin;
  assign res_fin = neg_q ? (~mag_fin + 1'b1) : mag_fin;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg_q    <= 1'b0;
      rem_op_q <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (w_in_valid) begin
            wa_q     <= w_rd;
            rem_op_q <= op_is_rem(w_op);
            // Quotient sign is the xor of operand signs; the remainder
            // follows the dividend.
            neg_q    <= op_is_rem(w_op) ? s1 : (s1 ^ s2);
            dvd_q    <= abs_val(w_rs1, s1);
            dvs_q    <= abs_val(w_rs2, s2);
            rem_q    <= '0;
            quo_q    <= '0;
            cnt      <= '0;
            if (div_zero || overflow) begin
              wd_q  <= special_res;
              state <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_q <= rem_next[XLEN-2:0];
          dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
          quo_q <= {quo_q[XLEN-3:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            wd_q  <= res_fin;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_out_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign w_in_ready  = (state == ST_IDLE);
  assign w_busy      = (state != ST_IDLE);
  assign w_out_valid = (state == ST_DONE);
  assign w_wa        = wa_q;
  assign w_wd        = wd_q;
  assign w_we        = w_out_valid & w_out_ack & (wa_q != 5'd0);
  assign w_dbg_state = state;

endmodule

// File: tb/tb_m_div_unit.sv
// Self-checking bench for m_div_unit: directed cases with literal
// expectations, randomized operations, and a per-cycle compare process
// against a behavioural model of the write-back interface.
module tb_m_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // ---------------- clock / reset / DUT ----------------
  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [1:0]  w_op = 2'b00;
  logic [31:0] w_rs1 = '0;
  logic [31:0] w_rs2 = '0;
  logic [4:0]  w_rd = '0;
  logic        w_busy;
  logic        w_out_valid;
  logic        w_out_ack = 1'b0;
  logic [4:0]  w_wa;
  logic [31:0] w_wd;
  logic        w_we;
  logic [1:0]  w_dbg_state;

  always #5 w_clk = ~w_clk;

  m_div_unit dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_in_valid  (w_in_valid),
    .w_in_ready  (w_in_ready),
    .w_op        (w_op),
    .w_rs1       (w_rs1),
    .w_rs2       (w_rs2),
    .w_rd        (w_rd),
    .w_busy      (w_busy),
    .w_out_valid (w_out_valid),
    .w_out_ack   (w_out_ack),
    .w_wa        (w_wa),
    .w_wd        (w_wd),
    .w_we        (w_we),
    .w_dbg_state (w_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic is_special(input logic [1:0] op,
                                      input logic [31:0] a, b);
    logic sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a, b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Expected queue: {rd, result}; at most one entry in flight.
  logic [36:0] exp_q[$];
  bit          outstanding = 0;
  bit          armed = 0;
  int          age = 0;
  int          exp_lat = 0;
  int          we_cnt = 0;

  // Compare process: every negedge, from the first reset onward.
  always @(negedge w_clk) begin
    bit         exp_valid;
    logic [4:0] erd;
    if (outstanding) age++;
    exp_valid = outstanding && (age >= exp_lat);
    erd = exp_valid ? exp_q[0][36:32] : 5'd0;
    if (armed) begin
      check("in_ready", w_in_ready, !outstanding);
      check("busy", w_busy, outstanding);
      check("out_valid", w_out_valid, exp_valid);
      check("we", w_we, exp_valid && w_out_ack && (erd != 5'd0));
      if (exp_valid) begin
        check("wa", w_wa, erd);
        check("wd", w_wd, exp_q[0][31:0]);
      end
    end
    if (w_we) we_cnt++;
    if (w_rst) begin
      outstanding = 0;
      exp_q.delete();
      armed = 1;
    end else if (exp_valid && w_out_ack) begin
      outstanding = 0;
      void'(exp_q.pop_front());
    end else if (!outstanding && w_in_valid) begin
      exp_q.push_back({w_rd, ref_result(w_op, w_rs1, w_rs2)});
      exp_lat = is_special(w_op, w_rs1, w_rs2) ? 1 : 33;
      age = 0;
      outstanding = 1;
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one op (unit must be idle), wait for the result, ack after
  // ack_dly cycles. lat counts edges from the accept edge to valid.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, b,
                       input logic [4:0] rd, input int ack_dly,
                       output logic [31:0] res, output int lat);
    @(posedge w_clk); #1;
    w_in_valid = 1'b1; w_op = op; w_rs1 = a; w_rs2 = b; w_rd = rd;
    @(posedge w_clk); #1;
    w_in_valid = 1'b0;
    w_rs1 = $urandom; w_rs2 = $urandom; w_rd = 5'($urandom);
    lat = 1;
    while (!w_out_valid && lat < 60) begin
      @(posedge w_clk); #1;
      lat++;
    end
    if (!w_out_valid) check("result_timeout", w_out_valid, 1'b1);
    res = w_wd;
    repeat (ack_dly) begin @(posedge w_clk); #1; end
    w_out_ack = 1'b1;
    @(posedge w_clk); #1;
    w_out_ack = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] res;
    int          lat;
    int          we0;

    // Model pins against hand-computed values.
    check("model_div_m7_2",  ref_result(OP_DIV,  32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem_m7_2",  ref_result(OP_REM,  32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_remu",      ref_result(OP_REMU, 32'hFFFF_FFF9, 32'd2), 32'd1);
    check("model_div_ovf",   ref_result(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    // Reset.
    w_rst = 1'b1;
    repeat (2) @(posedge w_clk);
    #1;
    check("rst_wa", w_wa, 5'd0);
    check("rst_wd", w_wd, 32'd0);
    check("rst_in_ready", w_in_ready, 1'b1);
    check("rst_busy", w_busy, 1'b0);
    check("rst_out_valid", w_out_valid, 1'b0);
    check("rst_we", w_we, 1'b0);
    w_rst = 1'b0;

    // DIVU 100/7 with ack held high.
    w_out_ack = 1'b1;
    @(posedge w_clk); #1;
    w_in_valid = 1'b1; w_op = OP_DIVU; w_rs1 = 32'd100; w_rs2 = 32'd7; w_rd = 5'd5;
    @(posedge w_clk); #1;
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 60) begin @(posedge w_clk); #1; lat++; end
    check("divu_lat", 32'(lat), 32'd33);
    check("divu_wd", w_wd, 32'd14);
    check("divu_wa", w_wa, 5'd5);
    check("divu_we", w_we, 1'b1);
    check("divu_ready_in_done", w_in_ready, 1'b0);
    @(posedge w_clk); #1;
    check("divu_ready_after", w_in_ready, 1'b1);
    check("divu_we_after", w_we, 1'b0);
    w_out_ack = 1'b0;

    // Signed and special cases with literal expectations.
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 0, res, lat);
    check("div_m7_2", res, 32'hFFFF_FFFD);
    check("div_m7_2_lat", 32'(lat), 32'd33);
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 1, res, lat);
    check("rem_m7_2", res, 32'hFFFF_FFFF);
    do_op(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, res, lat);
    check("remu", res, 32'd1);
    do_op(OP_DIV, 32'h1234, 32'd0, 5'd4, 0, res, lat);
    check("div_by0", res, 32'hFFFF_FFFF);
    check("div_by0_lat", 32'(lat), 32'd1);
    do_op(OP_REM, 32'h1234, 32'd0, 5'd4, 2, res, lat);
    check("rem_by0", res, 32'h1234);
    check("rem_by0_lat", 32'(lat), 32'd1);
    do_op(OP_DIVU, 32'h1234, 32'd0, 5'd6, 0, res, lat);
    check("divu_by0", res, 32'hFFFF_FFFF);
    do_op(OP_REMU, 32'h1234, 32'd0, 5'd6, 0, res, lat);
    check("remu_by0", res, 32'h1234);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, res, lat);
    check("div_ovf", res, 32'h8000_0000);
    check("div_ovf_lat", 32'(lat), 32'd1);
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, res, lat);
    check("rem_ovf", res, 32'd0);

    // Hold ack low 10 cycles in DONE; a second request is ignored.
    @(posedge w_clk); #1;
    w_in_valid = 1'b1; w_op = OP_DIVU; w_rs1 = 32'd1000; w_rs2 = 32'd10; w_rd = 5'd3;
    @(posedge w_clk); #1;
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 60) begin @(posedge w_clk); #1; lat++; end
    we0 = we_cnt;
    w_in_valid = 1'b1; w_op = OP_DIV; w_rs1 = 32'd77; w_rs2 = 32'd0; w_rd = 5'd9;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", w_out_valid, 1'b1);
      check("hold_wa", w_wa, 5'd3);
      check("hold_wd", w_wd, 32'd100);
      check("hold_ready", w_in_ready, 1'b0);
      @(posedge w_clk); #1;
    end
    w_in_valid = 1'b0;
    w_out_ack = 1'b1;
    @(posedge w_clk); #1;
    w_out_ack = 1'b0;
    @(posedge w_clk); #1;
    check("hold_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("hold_idle", w_in_ready, 1'b1);

    // Reset at CALC cycle 15 aborts the operation.
    we0 = we_cnt;
    @(posedge w_clk); #1;
    w_in_valid = 1'b1; w_op = OP_DIVU; w_rs1 = 32'hFFFF; w_rs2 = 32'd3; w_rd = 5'd8;
    @(posedge w_clk); #1;
    w_in_valid = 1'b0;
    w_out_ack = 1'b1;
    repeat (15) begin @(posedge w_clk); #1; end
    w_rst = 1'b1;
    @(posedge w_clk); #1;
    w_rst = 1'b0;
    check("abort_busy", w_busy, 1'b0);
    check("abort_valid", w_out_valid, 1'b0);
    check("abort_ready", w_in_ready, 1'b1);
    repeat (40) begin @(posedge w_clk); #1; end
    w_out_ack = 1'b0;
    check("abort_no_we", 32'(we_cnt - we0), 32'd0);
    do_op(OP_DIVU, 32'd9, 32'd3, 5'd10, 0, res, lat);
    check("after_abort", res, 32'd3);

    // rd = x0: full execution, never writes.
    we0 = we_cnt;
    do_op(OP_DIVU, 32'd8, 32'd2, 5'd0, 2, res, lat);
    check("rd0_res", res, 32'd4);
    check("rd0_no_we", 32'(we_cnt - we0), 32'd0);
    @(posedge w_clk); #1;
    check("rd0_idle", w_in_ready, 1'b1);

    // Randomized operations.
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = rand_operand();
      b  = rand_operand();
      do_op(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 3), res, lat);
      check("rand_res", res, ref_result(op, a, b));
      check("rand_lat", 32'(lat), is_special(op, a, b) ? 32'd1 : 32'd33);
    end

    repeat (3) @(posedge w_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/m_div_unit.md
Name: m_div_unit

Overview:
- Iterative RV32M divide/remainder unit: DIV, DIVU, REM, REMU.
- Sits between issue/execute and the register-file write port.
- Accepts operands read from the RF (rs1, rs2) with the destination index.
- Produces a write-back request (address, data, write enable) that drives the RF write port directly, with a valid/ack handshake toward write-back arbitration.

Parameters:
- XLEN, 32, operand/result width (only 32 is supported).
- CNT_W, 6, iteration-counter width (must hold XLEN).

Ports:
- w_clk  input  1  clock; all state updates on the rising edge.
- w_rst  input  1  synchronous, active-high reset.
- w_in_valid  input  1  operation request.
- w_in_ready  output  1  high only in IDLE.
- w_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- w_rs1  input  32  dividend.
- w_rs2  input  32  divisor.
- w_rd  input  5  destination register index.
- w_busy  output  1  high in CALC or DONE.
- w_out_valid  output  1  result pending (DONE state).
- w_out_ack  input  1  write-back has taken the result.
- w_wa  output  5  RF write address (latched rd).
- w_wd  output  32  RF write data (result).
- w_we  output  1  equals w_out_valid & w_out_ack & (w_wa != 0).

Behaviour:
- Reset:
  - Applied on the rising edge when w_rst=1.
  - State goes to IDLE; counter=0.
  - Outputs: w_out_valid=0, w_we=0, w_busy=0, w_in_ready=1, w_wa=0, w_wd=0.
  - Reset asserted mid-CALC or mid-DONE aborts the operation; the result is discarded and never written.
- Accept:
  - Occurs on the edge where w_in_valid & w_in_ready.
  - Latches op, rd, signs, |rs1|, |rs2|. Absolute values apply for signed ops only.
  - Inputs are ignored while not in IDLE.
- States:
  - IDLE -> DONE: on accept with a special case.
  - IDLE -> CALC: on accept otherwise; counter=0.
  - CALC: one radix-2 restoring step per cycle.
    - remainder = {rem[30:0], dividend msb}; dividend shifts left.
    - If remainder >= divisor: subtract and set quotient bit.
    - After 32 steps (counter==31 on that edge), go to DONE.
  - DONE: hold w_out_valid=1 and stable w_wa/w_wd until w_out_ack=1, then IDLE.
- Latency:
  - Normal: w_out_valid rises 33 cycles after the accept edge (accept edge + 32 CALC edges).
  - Special cases: 1 cycle.
  - Ack on the first DONE cycle gives w_in_ready=1 the next cycle. Throughput is 1 op per 34 cycles minimum.
- Sign fix-up, applied on the CALC->DONE edge:
  - Quotient negated if sign(rs1) != sign(rs2) (DIV).
  - Remainder takes the sign of rs1 (REM).
- Special cases (RISC-V spec), resolved at accept:
  - Divisor 0: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = rs1 (REM and REMU).
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Arithmetic:
  - All internal datapath 32 bits unsigned.
  - Trial subtraction uses a 33-bit difference; the borrow bit selects restore.
- rd=0: the operation executes fully and w_out_valid asserts. w_we stays 0 and the ack still retires the operation.
- w_out_ack while w_out_valid=0 is ignored.

Decomposition:
- Shared package (m_rv_pkg) holds:
  - Op encodings: OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - State encodings: ST_IDLE, ST_CALC, ST_DONE.
  - XLEN constant.
- One sub-module: m_div_step, the combinational single restoring step (remainder, dividend msb, divisor -> next remainder, quotient bit). It keeps the FSM file small.

Test Plan:
- DIVU 100/7, rd=5, ack held 1 -> w_out_valid 33 cycles after accept; w_wd=14, w_wa=5, w_we pulses 1 cycle; w_in_ready returns next cycle.
- DIV -7/2 and REM -7/2 -> 0xFFFFFFFD (-3) and 0xFFFFFFFF (-1); REMU 0xFFFFFFF9/2 -> 1.
- DIV x/0 with x=0x1234 -> 0xFFFFFFFF in 1 cycle; REM x/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Hold w_out_ack=0 for 10 cycles after DONE -> w_out_valid, w_wa, w_wd stable; w_in_ready=0; a second w_in_valid is ignored; ack -> exactly one w_we pulse.
- Assert w_rst at CALC cycle 15 -> next cycle IDLE, w_busy=0, w_out_valid=0; no w_we ever; a new DIVU 9/3 then gives 3.
- rd=0 DIVU 8/2 -> w_out_valid=1, w_we stays 0 through ack; unit returns to IDLE.
